// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80-style I/O cycle sequencer: FSM states,
// transfer direction constants and a small direction helper.
package z80_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } io_state_t;

    localparam logic IO_RD = 1'b0;
    localparam logic IO_WR = 1'b1;

    function automatic logic is_write(input logic we);
        return we == IO_WR;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin decision: when both requesters ask, the one that did
// not win last time gets the bus; a single request always wins.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic en,
    input  logic last_gnt,
    output logic gnt,
    output logic gnt_id
);

    // Pure combinational grant selection, only active while the sequencer is idle
    always_comb begin
        gnt    = 1'b0;
        gnt_id = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt    = 1'b1;
                gnt_id = ~last_gnt;
            end else if (req0) begin
                gnt    = 1'b1;
                gnt_id = 1'b0;
            end else if (req1) begin
                gnt    = 1'b1;
                gnt_id = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_cycle_arbiter_z80.sv
// Sequences Z80-style I/O read/write cycles (IORQ/RD/WR) towards the
// bus-monitor register file, sharing the bus between the host command port
// (requester 0) and the poll engine (requester 1). Every output is a flop.
import z80_bus_pkg::*;

module io_cycle_arbiter_z80 #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic       clk_cpu,
    input  logic       reset_cpu,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] adr0,
    input  logic [7:0] adr1,
    input  logic [7:0] wdat0,
    input  logic [7:0] wdat1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdat,
    output logic [7:0] a_bus,
    output logic [7:0] d_out,
    output logic       d_oe,
    input  logic [7:0] d_in,
    output logic       io_req_n,
    output logic       rd_n,
    output logic       wr_n
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

    io_state_t  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       last_gnt_q, last_gnt_d;
    logic       id_q, id_d;
    logic       we_q, we_d;
    logic [7:0] a_bus_q, a_bus_d;
    logic [7:0] d_out_q, d_out_d;
    logic       d_oe_q, d_oe_d;
    logic       io_req_n_q, io_req_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic [7:0] rdat_q, rdat_d;

    logic       gnt;
    logic       gnt_id;
    logic       sel_we;
    logic [7:0] sel_adr;
    logic [7:0] sel_wdat;

    rr_arbiter2 u_rr (
        .req0     (req0),
        .req1     (req1),
        .en       (state_q == ST_IDLE),
        .last_gnt (last_gnt_q),
        .gnt      (gnt),
        .gnt_id   (gnt_id)
    );

    // Next-state and next-output computation for the IDLE/SETUP/STROBE/HOLD cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        id_d       = id_q;
        we_d       = we_q;
        a_bus_d    = a_bus_q;
        d_out_d    = d_out_q;
        d_oe_d     = d_oe_q;
        io_req_n_d = io_req_n_q;
        rd_n_d     = rd_n_q;
        wr_n_d     = wr_n_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        rdat_d     = rdat_q;

        sel_we   = gnt_id ? we1   : we0;
        sel_adr  = gnt_id ? adr1  : adr0;
        sel_wdat = gnt_id ? wdat1 : wdat0;

        case (state_q)
            ST_IDLE: begin
                if (gnt) begin
                    state_d    = ST_SETUP;
                    last_gnt_d = gnt_id;
                    id_d       = gnt_id;
                    we_d       = sel_we;
                    a_bus_d    = sel_adr;
                    if (is_write(sel_we)) begin
                        d_out_d = sel_wdat;
                        d_oe_d  = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d    = ST_STROBE;
                cnt_d      = WAIT_LOAD;
                io_req_n_d = 1'b0;
                rd_n_d     = is_write(we_q);
                wr_n_d     = ~is_write(we_q);
            end
            ST_STROBE: begin
                if (cnt_q == 3'd0) begin
                    state_d    = ST_HOLD;
                    io_req_n_d = 1'b1;
                    rd_n_d     = 1'b1;
                    wr_n_d     = 1'b1;
                    if (!is_write(we_q)) begin
                        rdat_d = d_in;
                    end
                    done0_d = ~id_q;
                    done1_d = id_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
                d_oe_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the bus and favours requester 0
    always_ff @(posedge clk_cpu) begin
        if (reset_cpu) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            last_gnt_q <= 1'b1;
            id_q       <= 1'b0;
            we_q       <= IO_RD;
            a_bus_q    <= 8'h00;
            d_out_q    <= 8'h00;
            d_oe_q     <= 1'b0;
            io_req_n_q <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rdat_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            id_q       <= id_d;
            we_q       <= we_d;
            a_bus_q    <= a_bus_d;
            d_out_q    <= d_out_d;
            d_oe_q     <= d_oe_d;
            io_req_n_q <= io_req_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rdat_q     <= rdat_d;
        end
    end

    assign done0    = done0_q;
    assign done1    = done1_q;
    assign rdat     = rdat_q;
    assign a_bus    = a_bus_q;
    assign d_out    = d_out_q;
    assign d_oe     = d_oe_q;
    assign io_req_n = io_req_n_q;
    assign rd_n     = rd_n_q;
    assign wr_n     = wr_n_q;

endmodule

// File: tb/tb_io_cycle_arbiter_z80.sv
// Bench for io_cycle_arbiter_z80: a WAIT_STATES=2 instance for the main
// scenarios plus WAIT_STATES=1 and 7 instances for strobe-width limits.
// Expected values come from a transaction-level model: latency W+3 edges
// counting the sampling edge, strobe width W+1, alternating grants, and a
// predicted register-file image for read data.
module tb_io_cycle_arbiter_z80;

    localparam int W = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [7:0] adr0, adr1, wdat0, wdat1;
    logic       done0, done1, d_oe, io_req_n, rd_n, wr_n;
    logic [7:0] rdat, a_bus, d_out, d_in;

    logic       zero_bit;
    logic [7:0] zero_byte;
    logic [7:0] adr_alt;
    logic       req0_w1, done0_w1, done1_w1, d_oe_w1, io_req_n_w1, rd_n_w1, wr_n_w1;
    logic [7:0] rdat_w1, a_bus_w1, d_out_w1, d_in_w1;
    logic       req0_w7, done0_w7, done1_w7, d_oe_w7, io_req_n_w7, rd_n_w7, wr_n_w7;
    logic [7:0] rdat_w7, a_bus_w7, d_out_w7, d_in_w7;

    logic [7:0] rf [256];
    logic [7:0] pm [256];

    int n_compared = 0;
    int n_failed   = 0;

    always #5 clk = ~clk;

    // Register-file responder: drives read data while RD is low, stores on WR
    assign d_in    = rd_n ? 8'h00 : rf[a_bus];
    assign d_in_w1 = rd_n_w1 ? 8'h00 : 8'hFF;
    assign d_in_w7 = rd_n_w7 ? 8'h00 : 8'hFF;

    always @(posedge clk) begin
        if (!io_req_n && !wr_n) rf[a_bus] = d_out;
    end

    io_cycle_arbiter_z80 #(.WAIT_STATES(W)) dut (
        .clk_cpu(clk), .reset_cpu(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .adr0(adr0), .adr1(adr1), .wdat0(wdat0), .wdat1(wdat1),
        .done0(done0), .done1(done1), .rdat(rdat),
        .a_bus(a_bus), .d_out(d_out), .d_oe(d_oe), .d_in(d_in),
        .io_req_n(io_req_n), .rd_n(rd_n), .wr_n(wr_n)
    );

    io_cycle_arbiter_z80 #(.WAIT_STATES(1)) dut_w1 (
        .clk_cpu(clk), .reset_cpu(reset),
        .req0(req0_w1), .req1(zero_bit), .we0(zero_bit), .we1(zero_bit),
        .adr0(adr_alt), .adr1(zero_byte), .wdat0(zero_byte), .wdat1(zero_byte),
        .done0(done0_w1), .done1(done1_w1), .rdat(rdat_w1),
        .a_bus(a_bus_w1), .d_out(d_out_w1), .d_oe(d_oe_w1), .d_in(d_in_w1),
        .io_req_n(io_req_n_w1), .rd_n(rd_n_w1), .wr_n(wr_n_w1)
    );

    io_cycle_arbiter_z80 #(.WAIT_STATES(7)) dut_w7 (
        .clk_cpu(clk), .reset_cpu(reset),
        .req0(req0_w7), .req1(zero_bit), .we0(zero_bit), .we1(zero_bit),
        .adr0(adr_alt), .adr1(zero_byte), .wdat0(zero_byte), .wdat1(zero_byte),
        .done0(done0_w7), .done1(done1_w7), .rdat(rdat_w7),
        .a_bus(a_bus_w7), .d_out(d_out_w7), .d_oe(d_oe_w7), .d_in(d_in_w7),
        .io_req_n(io_req_n_w7), .rd_n(rd_n_w7), .wr_n(wr_n_w7)
    );

    // Bus-safety invariants checked on every cycle outside reset
    always @(negedge clk) begin
        if (!reset) begin
            n_compared++;
            if (!rd_n && !wr_n) begin
                n_failed++;
                $display("[TB] FAIL strobe_overlap: rd_n=%b wr_n=%b, required not both low", rd_n, wr_n);
            end
            n_compared++;
            if (!rd_n && d_oe) begin
                n_failed++;
                $display("[TB] FAIL oe_during_read: d_oe=%b while rd_n=0, required 0", d_oe);
            end
            n_compared++;
            if (done0 && done1) begin
                n_failed++;
                $display("[TB] FAIL done_overlap: done0=%b done1=%b, required not both 1", done0, done1);
            end
            n_compared++;
            if ((!rd_n_w1 && d_oe_w1) || (!rd_n_w7 && d_oe_w7) || !wr_n_w1 || !wr_n_w7) begin
                n_failed++;
                $display("[TB] FAIL alt_read_bus: d_oe_w1=%b wr_n_w1=%b d_oe_w7=%b wr_n_w7=%b, required 0/1/0/1",
                         d_oe_w1, wr_n_w1, d_oe_w7, wr_n_w7);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one transaction from requester id and measure what the bus does until done
    task automatic applyStimulus(input int id, input logic we, input logic [7:0] adr,
                                 input logic [7:0] wdat, input logic scramble,
                                 output int lat, output int wr_low, output int rd_low,
                                 output int oe_cyc, output int adr_bad, output int dout_bad,
                                 output int other);
        lat = 0; wr_low = 0; rd_low = 0; oe_cyc = 0; adr_bad = 0; dout_bad = 0; other = 0;
        @(negedge clk);
        if (id == 0) begin req0 = 1'b1; we0 = we; adr0 = adr; wdat0 = wdat; end
        else         begin req1 = 1'b1; we1 = we; adr1 = adr; wdat1 = wdat; end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (!wr_n) wr_low++;
            if (!rd_n) rd_low++;
            if (d_oe) oe_cyc++;
            if (a_bus !== adr) adr_bad++;
            if (we && d_out !== wdat) dout_bad++;
            if ((id == 0) ? done1 : done0) other++;
            if (scramble && n >= 2) begin
                if (id == 0) begin adr0 = 8'($urandom); wdat0 = 8'($urandom); end
                else         begin adr1 = 8'($urandom); wdat1 = 8'($urandom); end
            end
            if ((id == 0) ? done0 : done1) begin
                lat = n;
                break;
            end
        end
        if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_compared++;
        if ({io_req_n, rd_n, wr_n} !== 3'b111) begin
            n_failed++;
            $display("[TB] FAIL reset_strobes: got %b, required 111", {io_req_n, rd_n, wr_n});
        end
        n_compared++;
        if ({a_bus, d_out, rdat} !== 24'h0) begin
            n_failed++;
            $display("[TB] FAIL reset_buses: a_bus=%h d_out=%h rdat=%h, required 00 00 00", a_bus, d_out, rdat);
        end
        n_compared++;
        if ({d_oe, done0, done1} !== 3'b000) begin
            n_failed++;
            $display("[TB] FAIL reset_flags: d_oe/done0/done1=%b, required 000", {d_oe, done0, done1});
        end
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        int lat, wl, rl, oe, ab, db, ot;
        applyStimulus(0, 1'b1, 8'h51, 8'hA5, 1'b0, lat, wl, rl, oe, ab, db, ot);
        n_compared++;
        if (lat != W + 3) begin n_failed++; $display("[TB] FAIL wr_latency: got %0d, required %0d", lat, W + 3); end
        n_compared++;
        if (wl != W + 1 || rl != 0) begin
            n_failed++; $display("[TB] FAIL wr_strobe: wr low %0d rd low %0d, required %0d and 0", wl, rl, W + 1);
        end
        n_compared++;
        if (oe != W + 3) begin n_failed++; $display("[TB] FAIL wr_oe_width: got %0d, required %0d", oe, W + 3); end
        n_compared++;
        if (ab != 0 || db != 0 || ot != 0) begin
            n_failed++; $display("[TB] FAIL wr_bus_values: adr_bad=%0d dout_bad=%0d other_done=%0d, required 0", ab, db, ot);
        end
        @(negedge clk);
        n_compared++;
        if (d_oe !== 1'b0 || done0 !== 1'b0) begin
            n_failed++; $display("[TB] FAIL wr_after_hold: d_oe=%b done0=%b, required 0 0", d_oe, done0);
        end
        n_compared++;
        if (rf[8'h51] !== 8'hA5) begin
            n_failed++; $display("[TB] FAIL wr_stored: regfile[51]=%h, required a5", rf[8'h51]);
        end
    endtask

    task automatic test_single_read();
        int lat, wl, rl, oe, ab, db, ot;
        rf[8'h52] = 8'h3C;
        applyStimulus(1, 1'b0, 8'h52, 8'h00, 1'b0, lat, wl, rl, oe, ab, db, ot);
        n_compared++;
        if (lat != W + 3) begin n_failed++; $display("[TB] FAIL rd_latency: got %0d, required %0d", lat, W + 3); end
        n_compared++;
        if (rdat !== 8'h3C) begin n_failed++; $display("[TB] FAIL rd_data: got %h, required 3c", rdat); end
        n_compared++;
        if (rl != W + 1 || wl != 0 || oe != 0) begin
            n_failed++; $display("[TB] FAIL rd_strobe: rd low %0d wr low %0d oe %0d, required %0d 0 0", rl, wl, oe, W + 1);
        end
        n_compared++;
        if (ab != 0 || ot != 0) begin
            n_failed++; $display("[TB] FAIL rd_bus_values: adr_bad=%0d other_done=%0d, required 0", ab, ot);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] t_adr [2];
        logic [7:0] t_wdat [2];
        logic       t_we [2];
        logic [7:0] s_adr, s_dout;
        logic       s_wr;
        int exp_id, last, cyc, got, id;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            rf[i] = 8'($urandom);
            pm[i] = rf[i];
        end
        for (int r = 0; r < 2; r++) begin
            t_adr[r] = 8'($urandom_range(0, 3)); t_wdat[r] = 8'($urandom); t_we[r] = 1'($urandom);
        end
        s_adr = 8'h00; s_dout = 8'h00; s_wr = 1'b0;
        @(negedge clk);
        we0 = t_we[0]; adr0 = t_adr[0]; wdat0 = t_wdat[0];
        we1 = t_we[1]; adr1 = t_adr[1]; wdat1 = t_wdat[1];
        req0 = 1'b1; req1 = 1'b1;
        exp_id = 0; last = -1; cyc = 0; got = 0;
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!io_req_n) begin s_adr = a_bus; s_dout = d_out; s_wr = !wr_n; end
            if (done0 || done1) begin
                id = done1 ? 1 : 0;
                n_compared++;
                if (id != exp_id) begin n_failed++; $display("[TB] FAIL rr_order: txn %0d went to %0d, required %0d", got, id, exp_id); end
                if (last >= 0) begin
                    n_compared++;
                    if (cyc - last != W + 4) begin
                        n_failed++; $display("[TB] FAIL rr_period: got %0d cycles, required %0d", cyc - last, W + 4);
                    end
                end
                n_compared++;
                if (s_adr !== t_adr[id] || s_wr !== t_we[id]) begin
                    n_failed++; $display("[TB] FAIL rr_strobe_target: adr %h wr %b, required %h %b", s_adr, s_wr, t_adr[id], t_we[id]);
                end
                n_compared++;
                if (t_we[id]) begin
                    if (s_dout !== t_wdat[id]) begin
                        n_failed++; $display("[TB] FAIL rr_wdata: got %h, required %h", s_dout, t_wdat[id]);
                    end
                    pm[t_adr[id]] = t_wdat[id];
                end else if (rdat !== pm[t_adr[id]]) begin
                    n_failed++; $display("[TB] FAIL rr_rdata: got %h, required %h", rdat, pm[t_adr[id]]);
                end
                last = cyc; got++; exp_id = 1 - exp_id;
                t_adr[id] = 8'($urandom_range(0, 3)); t_wdat[id] = 8'($urandom); t_we[id] = 1'($urandom);
                if (id == 0) begin we0 = t_we[0]; adr0 = t_adr[0]; wdat0 = t_wdat[0]; end
                else         begin we1 = t_we[1]; adr1 = t_adr[1]; wdat1 = t_wdat[1]; end
            end
        end
        n_compared++;
        if (got < 8) begin n_failed++; $display("[TB] FAIL rr_timeout: %0d transactions, required 8", got); end
        req0 = 1'b0; req1 = 1'b0;
        repeat (W + 6) @(negedge clk);
    endtask

    task automatic test_reset_mid_cycle();
        int order [$];
        do_reset();
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; adr0 = 8'h10;
        repeat (3) @(negedge clk);
        n_compared++;
        if (rd_n !== 1'b0) begin n_failed++; $display("[TB] FAIL abort_precond: rd_n=%b, required 0", rd_n); end
        reset = 1'b1; req0 = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({io_req_n, rd_n, wr_n, d_oe} !== 4'b1110) begin
            n_failed++; $display("[TB] FAIL abort_release: iorq/rd/wr/oe=%b, required 1110", {io_req_n, rd_n, wr_n, d_oe});
        end
        for (int k = 0; k < 3; k++) begin
            n_compared++;
            if (done0 || done1) begin n_failed++; $display("[TB] FAIL abort_no_done: done0=%b done1=%b, required 0 0", done0, done1); end
            @(negedge clk);
        end
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; adr0 = 8'h11;
        req1 = 1'b1; we1 = 1'b0; adr1 = 8'h12;
        for (int n = 0; n < 40 && order.size() < 2; n++) begin
            @(negedge clk);
            if (done0) begin order.push_back(0); req0 = 1'b0; end
            if (done1) begin order.push_back(1); req1 = 1'b0; end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_compared++;
        if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
            n_failed++; $display("[TB] FAIL abort_rearb: %0d dones, first %0d, required 2 with 0 first",
                                 order.size(), (order.size() > 0) ? order[0] : -1);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wait_range();
        int lat1, lat7, rl1, rl7;
        lat1 = 0; lat7 = 0; rl1 = 0; rl7 = 0;
        @(negedge clk);
        adr_alt = 8'($urandom);
        req0_w1 = 1'b1; req0_w7 = 1'b1;
        for (int n = 1; n <= 30 && (lat1 == 0 || lat7 == 0); n++) begin
            @(negedge clk);
            if (!rd_n_w1) rl1++;
            if (!rd_n_w7) rl7++;
            if (done0_w1 && lat1 == 0) begin lat1 = n; req0_w1 = 1'b0; end
            if (done0_w7 && lat7 == 0) begin lat7 = n; req0_w7 = 1'b0; end
        end
        req0_w1 = 1'b0; req0_w7 = 1'b0;
        n_compared++;
        if (rl1 != 2 || lat1 != 4) begin n_failed++; $display("[TB] FAIL ws1_timing: strobe %0d latency %0d, required 2 4", rl1, lat1); end
        n_compared++;
        if (rl7 != 8 || lat7 != 10) begin n_failed++; $display("[TB] FAIL ws7_timing: strobe %0d latency %0d, required 8 10", rl7, lat7); end
        n_compared++;
        if (rdat_w1 !== 8'hFF || rdat_w7 !== 8'hFF) begin
            n_failed++; $display("[TB] FAIL ws_rdata: w1 %h w7 %h, required ff ff", rdat_w1, rdat_w7);
        end
    endtask

    task automatic test_late_change();
        int lat, wl, rl, oe, ab, db, ot;
        applyStimulus(0, 1'b1, 8'h20, 8'h77, 1'b1, lat, wl, rl, oe, ab, db, ot);
        n_compared++;
        if (ab != 0 || db != 0) begin
            n_failed++; $display("[TB] FAIL late_change: adr_bad=%0d dout_bad=%0d, required 0 0", ab, db);
        end
        n_compared++;
        if (lat != W + 3 || wl != W + 1) begin
            n_failed++; $display("[TB] FAIL late_timing: latency %0d strobe %0d, required %0d %0d", lat, wl, W + 3, W + 1);
        end
    endtask

    task automatic test_random_single();
        int lat, wl, rl, oe, ab, db, ot, id;
        logic we;
        logic [7:0] adr, wdat, last_read;
        for (int i = 0; i < 256; i++) begin
            rf[i] = 8'($urandom);
            pm[i] = rf[i];
        end
        last_read = rdat;
        for (int t = 0; t < 10; t++) begin
            id = int'($urandom_range(0, 1)); we = 1'($urandom);
            adr = 8'($urandom_range(0, 7)); wdat = 8'($urandom);
            applyStimulus(id, we, adr, wdat, 1'b0, lat, wl, rl, oe, ab, db, ot);
            n_compared++;
            if (lat != W + 3 || ot != 0 || ab != 0) begin
                n_failed++; $display("[TB] FAIL rnd_txn%0d: latency %0d other %0d adr_bad %0d, required %0d 0 0", t, lat, ot, ab, W + 3);
            end
            n_compared++;
            if ((we ? wl : rl) != W + 1 || (we ? rl : wl) != 0 || oe != (we ? W + 3 : 0)) begin
                n_failed++; $display("[TB] FAIL rnd_strobe%0d: wr %0d rd %0d oe %0d for we=%b", t, wl, rl, oe, we);
            end
            n_compared++;
            if (we) begin
                pm[adr] = wdat;
                if (rdat !== last_read || db != 0) begin
                    n_failed++; $display("[TB] FAIL rnd_hold%0d: rdat %h dout_bad %0d, required %h 0", t, rdat, db, last_read);
                end
            end else begin
                if (rdat !== pm[adr]) begin
                    n_failed++; $display("[TB] FAIL rnd_read%0d: got %h, required %h", t, rdat, pm[adr]);
                end
                last_read = pm[adr];
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        adr0 = 8'h00; adr1 = 8'h00; wdat0 = 8'h00; wdat1 = 8'h00;
        zero_bit = 1'b0; zero_byte = 8'h00; adr_alt = 8'h00;
        req0_w1 = 1'b0; req0_w7 = 1'b0;
        for (int i = 0; i < 256; i++) rf[i] = 8'h00;
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_reset_mid_cycle();
        test_wait_range();
        test_late_change();
        test_random_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
